alu_frame_sequencer: RTL and testbench

ALU_FRAME_SEQUENCER -- requirements
Module: alu_frame_sequencer

---
 rtl/alu_frame_sequencer_pkg.sv | 30 +++
 rtl/alu_frame_sequencer_if.sv | 24 ++
 rtl/alu_result_reg.sv | 32 +++
 rtl/alu_frame_sequencer.sv | 88 ++++++++
 tb/tb_alu_frame_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_frame_sequencer_pkg.sv
// Shared ALU definitions: command codes, sequencer state encoding and result record.
// The ALU and the frame sequencer both import this package.
package alu_frame_sequencer_pkg;

    localparam logic [3:0] CMD_ADD = 4'h0;
    localparam logic [3:0] CMD_SUB = 4'h1;
    localparam logic [3:0] CMD_INV = 4'h2;
    localparam logic [3:0] CMD_AND = 4'h3;
    localparam logic [3:0] CMD_OR  = 4'h4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_A,
        ST_GET_B,
        ST_EXEC,
        ST_HOLD
    } state_t;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  cmd;
        logic        err;
    } result_t;

    // Codes above OR are reserved and reported as errors.
    function automatic logic cmd_legal(input logic [3:0] cmd);
        return cmd <= CMD_OR;
    endfunction

endpackage

// File: rtl/alu_frame_sequencer_if.sv
// Byte-stream input and result handshake of the ALU frame sequencer.
// master = upstream/downstream environment, slave = the sequencer.
interface alu_frame_sequencer_if;

    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [3:0]  res_cmd;
    logic        res_err;

    modport master (
        output in_valid, in_data, res_ready,
        input  in_ready, res_valid, res_data, res_cmd, res_err
    );

    modport slave (
        input  in_valid, in_data, res_ready,
        output in_ready, res_valid, res_data, res_cmd, res_err
    );

endinterface

// File: rtl/alu_result_reg.sv
// Result holding register: loaded at the end of EXEC, presented with res_valid
// until the consumer takes it.
module alu_result_reg
    import alu_frame_sequencer_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    load,
    input  result_t load_res,
    input  logic    res_ready,
    output logic    res_valid,
    output result_t res,
    output logic    handshake
);

    assign handshake = res_valid && res_ready;

    // NOTE: non-blocking assignments on every flop so all registers update
    // from pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res      <= '0;
        end else if (load) begin
            res_valid <= 1'b1;
            res       <= load_res;
        end else if (handshake) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_frame_sequencer.sv
// Collects {cmd, op1[, op2]} byte frames, drives an external ALU for one cycle
// and hands the captured result downstream through a valid/ready handshake.
module alu_frame_sequencer
    import alu_frame_sequencer_pkg::*;
#(
    parameter bit INV_SINGLE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_frame_sequencer_if.slave  bus,
    output logic [7:0]            alu_op1,
    output logic [7:0]            alu_op2,
    output logic [3:0]            alu_cmd,
    input  logic [15:0]           alu_result
);

    state_t  state_q, state_d;
    logic    accept;
    logic    handshake;
    result_t exec_res;
    result_t held_res;

    // Ready is gated by rst_n so it reads 0 while reset is held.
    assign bus.in_ready = rst_n && (state_q == ST_IDLE || state_q == ST_GET_A ||
                                    state_q == ST_GET_B);
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: state_d gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_GET_A;
            ST_GET_A: if (accept) state_d = (INV_SINGLE && alu_cmd == CMD_INV) ? ST_EXEC : ST_GET_B;
            ST_GET_B: if (accept) state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_HOLD;
            ST_HOLD:  if (handshake) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Operands clear on the command byte so a skipped operand 2 reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_cmd <= '0;
            alu_op1 <= '0;
            alu_op2 <= '0;
        end else if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    alu_cmd <= bus.in_data[3:0];
                    alu_op1 <= '0;
                    alu_op2 <= '0;
                end
                ST_GET_A: alu_op1 <= bus.in_data;
                ST_GET_B: alu_op2 <= bus.in_data;
                default:  ;
            endcase
        end
    end

    always_comb begin
        exec_res.data = cmd_legal(alu_cmd) ? alu_result : 16'h0000;
        exec_res.cmd  = alu_cmd;
        exec_res.err  = !cmd_legal(alu_cmd);
    end

    alu_result_reg u_result_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (state_q == ST_EXEC),
        .load_res  (exec_res),
        .res_ready (bus.res_ready),
        .res_valid (bus.res_valid),
        .res       (held_res),
        .handshake (handshake)
    );

    assign bus.res_data = held_res.data;
    assign bus.res_cmd  = held_res.cmd;
    assign bus.res_err  = held_res.err;

endmodule

// File: tb/tb_alu_frame_sequencer.sv
// Self-checking bench for alu_frame_sequencer: directed frame table (gapless and
// gapped), reset/stall corner sequences and randomized frames against a model.
module tb_alu_frame_sequencer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  alu_op1;
    logic [7:0]  alu_op2;
    logic [3:0]  alu_cmd;
    logic [15:0] alu_result;

    int checks   = 0;
    int failures = 0;

    alu_frame_sequencer_if bus ();

    alu_frame_sequencer #(.INV_SINGLE(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_cmd    (alu_cmd),
        .alu_result (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the downstream combinational ALU; illegal codes give junk.
    always_comb begin
        case (alu_cmd)
            4'h0:    alu_result = {8'h00, alu_op1} + {8'h00, alu_op2};
            4'h1:    alu_result = {8'h00, alu_op1} - {8'h00, alu_op2};
            4'h2:    alu_result = ~{8'h00, alu_op1};
            4'h3:    alu_result = {8'h00, alu_op1 & alu_op2};
            4'h4:    alu_result = {8'h00, alu_op1 | alu_op2};
            default: alu_result = 16'hDEAD;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  c;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_data;
        logic [3:0]  exp_cmd;
        logic        exp_err;
        int          stall;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Frame-level reference: {err, data} from the command and operand bytes.
    function automatic logic [16:0] ref_result(input logic [7:0] c, input logic [7:0] a,
                                               input logic [7:0] b);
        int x;
        int y;
        x = a;
        y = b;
        case (c[3:0])
            4'h0:    return {1'b0, 16'((x + y) & 32'hFFFF)};
            4'h1:    return {1'b0, 16'((x - y) & 32'hFFFF)};
            4'h2:    return {1'b0, 16'(32'hFFFF ^ x)};
            4'h3:    return {1'b0, 16'(x & y)};
            4'h4:    return {1'b0, 16'(x | y)};
            default: return {1'b1, 16'h0000};
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("byte_accept", bus.in_ready, 1'b1);
        if (bus.in_ready) begin
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b,
                              input int gap);
        send_byte(c);
        repeat (gap) @(negedge clk);
        send_byte(a);
        if (c[3:0] != 4'h2) begin
            repeat (gap) @(negedge clk);
            send_byte(b);
        end
    endtask

    // Starts at the negedge right after the last byte was accepted (EXEC cycle).
    task automatic recv_result(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] exp_data, input logic [3:0] exp_cmd,
                               input logic exp_err, input int stall);
        logic [7:0] exp_op2;
        int n = 0;
        exp_op2 = (c[3:0] == 4'h2) ? 8'h00 : b;
        check("exec_res_valid", bus.res_valid, 1'b0);
        check("exec_in_ready", bus.in_ready, 1'b0);
        check("exec_alu_cmd", alu_cmd, c[3:0]);
        check("exec_alu_op1", alu_op1, a);
        check("exec_alu_op2", alu_op2, exp_op2);
        @(negedge clk);
        check("latency_res_valid", bus.res_valid, 1'b1);
        while (!bus.res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.res_valid) return;
        for (int i = 0; i < stall; i++) begin
            check("stall_res_data", bus.res_data, exp_data);
            check("stall_in_ready", bus.in_ready, 1'b0);
            check("stall_res_valid", bus.res_valid, 1'b1);
            @(negedge clk);
        end
        check("res_data", bus.res_data, exp_data);
        check("res_cmd", bus.res_cmd, exp_cmd);
        check("res_err", bus.res_err, exp_err);
        check("hold_alu_op2", alu_op2, exp_op2);
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("after_hs_res_valid", bus.res_valid, 1'b0);
        check("after_hs_in_ready", bus.in_ready, 1'b1);
    endtask

    initial begin
        logic [7:0]  c, a, b;
        logic [16:0] r;
        int          gap, stall;

        vecs[0] = '{8'h00, 8'hFF, 8'h01, 16'h0100, 4'h0, 1'b0, 0};
        vecs[1] = '{8'h01, 8'h05, 8'h07, 16'hFFFE, 4'h1, 1'b0, 0};
        vecs[2] = '{8'h02, 8'h0F, 8'h77, 16'hFFF0, 4'h2, 1'b0, 0};
        vecs[3] = '{8'h09, 8'hAA, 8'h55, 16'h0000, 4'h9, 1'b1, 0};
        vecs[4] = '{8'h03, 8'hF0, 8'h3C, 16'h0030, 4'h3, 1'b0, 5};
        vecs[5] = '{8'h04, 8'h12, 8'h34, 16'h0036, 4'h4, 1'b0, 0};
        vecs[6] = '{8'hF0, 8'h80, 8'h80, 16'h0100, 4'h0, 1'b0, 1};
        vecs[7] = '{8'h1F, 8'h01, 8'h02, 16'h0000, 4'hF, 1'b1, 0};

        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.res_ready = 1'b0;
        rst_n         = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_res_valid", bus.res_valid, 1'b0);
        check("rst_alu_op1", alu_op1, 8'h00);
        check("rst_alu_op2", alu_op2, 8'h00);
        check("rst_alu_cmd", alu_cmd, 4'h0);
        check("rst_res_data", bus.res_data, 16'h0000);
        check("rst_res_cmd", bus.res_cmd, 4'h0);
        check("rst_res_err", bus.res_err, 1'b0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);

        // res_ready outside HOLD has no effect
        bus.res_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_ready_res_valid", bus.res_valid, 1'b0);
            check("idle_ready_in_ready", bus.in_ready, 1'b1);
        end
        bus.res_ready = 1'b0;

        // Directed table: gapless pass, then a gapped pass with identical expectations
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 8; i++) begin
                send_frame(vecs[i].c, vecs[i].a, vecs[i].b, g);
                recv_result(vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].exp_data,
                            vecs[i].exp_cmd, vecs[i].exp_err, vecs[i].stall);
                repeat (g) @(negedge clk);
            end
        end

        // Reset after two bytes of a frame discards it
        send_byte(8'h04);
        send_byte(8'h12);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", bus.in_ready, 1'b0);
        check("midrst_alu_op1", alu_op1, 8'h00);
        check("midrst_alu_cmd", alu_cmd, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_result", bus.res_valid, 1'b0);
        end
        send_frame(8'h04, 8'h12, 8'h34, 0);
        recv_result(8'h04, 8'h12, 8'h34, 16'h0036, 4'h4, 1'b0, 0);
        repeat (6) begin
            @(negedge clk);
            check("single_result", bus.res_valid, 1'b0);
        end

        // Reset in HOLD drops the pending result
        send_frame(8'h00, 8'h01, 8'h01, 0);
        @(negedge clk);
        check("hold_before_rst", bus.res_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("holdrst_res_valid", bus.res_valid, 1'b0);
        check("holdrst_res_data", bus.res_data, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("holdrst_no_result", bus.res_valid, 1'b0);
        end

        // Randomized frames against the reference model
        for (int i = 0; i < 150; i++) begin
            c = 8'($urandom);
            if ($urandom_range(0, 7) != 0) c[3:0] = 4'($urandom_range(0, 4));
            a     = 8'($urandom);
            b     = 8'($urandom);
            gap   = $urandom_range(0, 2);
            stall = $urandom_range(0, 3);
            r     = ref_result(c, a, b);
            send_frame(c, a, b, gap);
            recv_result(c, a, b, r[15:0], c[3:0], r[16], stall);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
